// File: rtl/spi_master_arbiter_pkg.sv
// spi_arb_pkg: shared types and width helpers for the SPI master arbiter.
//   state_t  - arbiter FSM state encoding
//   clog2    - ceil(log2(v)), usable in parameter expressions
//   id_w     - width of a requester index (at least 1 bit)
//   cnt_w    - width of the shared state counter: clog2(max of params) + 1
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SEND    = 3'd2,
        WAIT_RX = 3'd3,
        GAP     = 3'd4
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return clog2(m) + 1;
    endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if: requester, response and engine signals of the arbiter.
//   master - arbiter view (drives req_ready, rsp_*, eng_data_tx/eng_tx_valid/
//            eng_rx_read, cs_n, busy, error)
//   slave  - environment view (requesters + byte engine)
interface spi_master_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();
    localparam int IDW = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0][7:0]   req_data;   // requester i in bits [8i+7:8i]
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic [7:0]                rsp_data;
    logic [IDW-1:0]            rsp_id;
    logic                      rsp_last;
    logic [7:0]                eng_data_tx;
    logic                      eng_tx_valid;
    logic                      eng_tx_ready;
    logic [7:0]                eng_data_rx;
    logic                      eng_rx_valid;
    logic                      eng_rx_read;
    logic [NUM_REQ-1:0]        cs_n;
    logic                      busy;
    logic                      error;

    modport master (
        input  req_valid, req_data, req_last, eng_tx_ready, eng_data_rx, eng_rx_valid,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_last,
               eng_data_tx, eng_tx_valid, eng_rx_read, cs_n, busy, error
    );

    modport slave (
        output req_valid, req_data, req_last, eng_tx_ready, eng_data_rx, eng_rx_valid,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_last,
               eng_data_tx, eng_tx_valid, eng_rx_read, cs_n, busy, error
    );
endinterface

// File: rtl/spi_master_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req        - request vector
//   last_grant - index served most recently; search starts one above it
//   grant      - first requesting index found, wrapping past NUM_REQ-1
//   any_req    - at least one request present
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     grant,
    output logic               any_req
);
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        any_req = 1'b0;
        // k = NUM_REQ revisits last_grant itself, so a lone requester can win again
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!any_req && req[idx[IDW-1:0]]) begin
                grant   = idx[IDW-1:0];
                any_req = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: shares one byte-level SPI engine among NUM_REQ requesters.
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   bus     - requester byte bursts, response stream, engine handshake,
//             per-requester cs_n, busy and error (master modport)
// A grant is held for a whole burst: SETUP (cs_n low before the first byte),
// SEND/WAIT_RX per byte, then GAP (all cs_n high) before the next arbitration.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi_master_arbiter_if.master  bus
);
    localparam int IDW = id_w(NUM_REQ);
    localparam int CW  = cnt_w(SETUP_CYC, GAP_CYC, TIMEOUT);
    localparam logic [NUM_REQ-1:0] SEL0 = NUM_REQ'(1);

    state_t         state, state_d;
    logic [IDW-1:0] grant, grant_d, last_grant, last_grant_d, pick;
    logic [CW-1:0]  cnt, cnt_d;
    logic           last_q, last_d, any_req;
    logic           hs, rx_take, tmo;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (any_req)
    );

    assign hs      = (state == SEND) && bus.req_valid[grant] && bus.eng_tx_ready;
    assign rx_take = (state == WAIT_RX) && bus.eng_rx_valid;
    // Timeout only counts cycles spent waiting for the engine, never requester stalls
    assign tmo     = (state == WAIT_RX) && !bus.eng_rx_valid && (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state;
        grant_d      = grant;
        last_d       = last_q;
        last_grant_d = last_grant;
        unique case (state)
            IDLE:    if (any_req) begin
                         grant_d = pick;
                         state_d = SETUP;
                     end
            SETUP:   if (cnt == CW'(SETUP_CYC - 1)) state_d = SEND;
            SEND:    if (hs) begin
                         last_d  = bus.req_last[grant];
                         state_d = WAIT_RX;
                     end
            WAIT_RX: if (rx_take)  state_d = last_q ? GAP : SEND;
                     else if (tmo) state_d = GAP;
            GAP:     if (cnt == CW'(GAP_CYC - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == GAP && state != GAP) last_grant_d = grant;
        // Counter clears on every state change and only runs in timed states
        cnt_d = '0;
        if (state_d == state && (state == SETUP || state == WAIT_RX || state == GAP))
            cnt_d = cnt + 1'b1;
    end

    // Engine/requester handoff is combinational so a byte moves in the SEND cycle
    always_comb begin
        bus.req_ready    = '0;
        bus.eng_tx_valid = 1'b0;
        bus.eng_data_tx  = '0;
        bus.eng_rx_read  = rx_take;
        if (state == SEND) begin
            bus.req_ready[grant] = bus.eng_tx_ready;
            bus.eng_tx_valid     = bus.req_valid[grant];
            bus.eng_data_tx      = bus.req_data[grant];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= IDW'(NUM_REQ - 1);
            cnt           <= '0;
            last_q        <= 1'b0;
            bus.cs_n      <= '1;
            bus.busy      <= 1'b0;
            bus.error     <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_last  <= 1'b0;
        end else begin
            state         <= state_d;
            grant         <= grant_d;
            last_grant    <= last_grant_d;
            cnt           <= cnt_d;
            last_q        <= last_d;
            bus.cs_n      <= (state_d == SETUP || state_d == SEND || state_d == WAIT_RX)
                             ? ~(SEL0 << grant_d) : '1;
            bus.busy      <= (state_d != IDLE);
            bus.error     <= tmo;
            bus.rsp_valid <= rx_take;
            if (rx_take) begin
                bus.rsp_data <= bus.eng_data_rx;
                bus.rsp_id   <= grant;
                bus.rsp_last <= last_q;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: self-checking bench for spi_master_arbiter.
// Requesters are queues of {last,byte}; the engine model answers each byte with
// its complement after a random delay. Expected responses and grant order come
// from a round-robin model over pending bursts.
module tb_spi_master_arbiter;
    import spi_arb_pkg::*;

    localparam int N = 4;
    localparam int TMO = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_arbiter_if #(.NUM_REQ(N)) bus ();

    spi_master_arbiter #(.NUM_REQ(N), .SETUP_CYC(2), .GAP_CYC(2), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // driver / engine model state
    logic [8:0]  txq [N][$];
    int          stall_left [N];
    int          stall_len = 0, stall_pct = 0;
    bit          rdy_rand = 0, eng_mute = 0, eng_pending = 0;
    int          rx_dly_max = 0, eng_wait = 0;
    logic [7:0]  eng_byte;
    int          exp_last = N - 1;

    // observations
    int          cyc, hs_first, obs_err, err_cyc, obs_multi;
    logic [N-1:0] err_cs;
    logic [10:0] obs_rsp [$];
    int          obs_rsp_cyc [$];
    int          grants [$];
    logic [N-1:0] hist_cs [$];
    logic        hist_busy [$];
    bit          cs_prev_idle = 1;

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (txq[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic clear_obs();
        cyc = 0; hs_first = -1; obs_err = 0; err_cyc = -1; obs_multi = 0; err_cs = '0;
        obs_rsp.delete(); obs_rsp_cyc.delete(); grants.delete();
        hist_cs.delete(); hist_busy.delete();
    endtask

    // One clock: observe registered outputs, drive inputs, sample handshakes.
    task automatic cycle();
        logic [8:0] h;
        @(negedge clk);
        if (bus.rsp_valid) begin
            obs_rsp.push_back({bus.rsp_id, bus.rsp_last, bus.rsp_data});
            obs_rsp_cyc.push_back(cyc);
        end
        if (bus.error) begin
            if (obs_err == 0) begin err_cyc = cyc; err_cs = bus.cs_n; end
            obs_err++;
        end
        if ($countones(~bus.cs_n) > 1) obs_multi++;
        if (cs_prev_idle && bus.cs_n != '1)
            for (int i = 0; i < N; i++) if (!bus.cs_n[i]) grants.push_back(i);
        cs_prev_idle = (bus.cs_n == '1);
        hist_cs.push_back(bus.cs_n);
        hist_busy.push_back(bus.busy);
        for (int i = 0; i < N; i++) begin
            if (stall_left[i] > 0) stall_left[i]--;
            if (txq[i].size() > 0 && stall_left[i] == 0) begin
                h = txq[i][0];
                bus.req_valid[i] = 1'b1; bus.req_data[i] = h[7:0]; bus.req_last[i] = h[8];
            end else begin
                bus.req_valid[i] = 1'b0; bus.req_data[i] = '0; bus.req_last[i] = 1'b0;
            end
        end
        bus.eng_tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (eng_pending && !eng_mute && eng_wait == 0) begin
            bus.eng_rx_valid = 1'b1; bus.eng_data_rx = ~eng_byte;
        end else begin
            bus.eng_rx_valid = 1'b0; bus.eng_data_rx = '0;
        end
        if (eng_pending && eng_wait > 0) eng_wait--;
        #4;
        for (int i = 0; i < N; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                h = txq[i].pop_front();
                if (hs_first < 0) hs_first = cyc;
                if (!h[8] && stall_pct > 0 && $urandom_range(1, 100) <= stall_pct)
                    stall_left[i] = stall_len;
            end
        if (bus.eng_rx_read) eng_pending = 0;
        if (bus.eng_tx_valid && bus.eng_tx_ready) begin
            eng_pending = 1; eng_byte = bus.eng_data_tx;
            eng_wait = $urandom_range(0, rx_dly_max);
        end
        cyc++;
    endtask

    task automatic run_idle(input int maxc, output bit ok);
        ok = 0;
        for (int k = 0; k < maxc; k++) begin
            cycle();
            if (k > 0 && queues_empty() && !eng_pending && hist_busy[$] == 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.req_valid = '1; bus.req_last = '1; bus.req_data = '1;
        bus.eng_tx_ready = 1'b1; bus.eng_rx_valid = 1'b1; bus.eng_data_rx = 8'hFF;
        repeat (3) @(negedge clk);
        total++;
        if (bus.cs_n !== 4'hF) begin bad++; $display("FAIL reset_cs_n got=%b want=1111", bus.cs_n); end
        total++;
        if (bus.req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
        total++;
        if ({bus.eng_tx_valid, bus.eng_rx_read, bus.busy, bus.error} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000", {bus.eng_tx_valid, bus.eng_rx_read, bus.busy, bus.error});
        end
        total++;
        if ({bus.rsp_valid, bus.rsp_last, bus.rsp_id, bus.rsp_data, bus.eng_data_tx} !== 20'h0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {bus.rsp_valid, bus.rsp_last, bus.rsp_id, bus.rsp_data, bus.eng_data_tx});
        end
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
        bus.eng_rx_valid = 1'b0; bus.eng_data_rx = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fairness();
        bit ok;
        logic [10:0] e;
        clear_obs(); rdy_rand = 0; rx_dly_max = 0; stall_pct = 0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) txq[i].push_back({1'b1, 8'(8'hA0 + 16 * r + i)});
        run_idle(400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fair_done got=timeout want=idle"); end
        total++;
        if (grants.size() != 8) begin bad++; $display("FAIL fair_ngrant got=%0d want=8", grants.size()); end
        for (int k = 0; k < grants.size() && k < 8; k++) begin
            total++;
            if (grants[k] != k % N) begin bad++; $display("FAIL fair_grant%0d got=%0d want=%0d", k, grants[k], k % N); end
        end
        total++;
        if (obs_rsp.size() != 8) begin bad++; $display("FAIL fair_nrsp got=%0d want=8", obs_rsp.size()); end
        for (int k = 0; k < obs_rsp.size() && k < 8; k++) begin
            e = {2'(k % N), 1'b1, ~8'(8'hA0 + 16 * (k / N) + k % N)};
            total++;
            if (obs_rsp[k] !== e) begin bad++; $display("FAIL fair_rsp%0d got=%h want=%h", k, obs_rsp[k], e); end
        end
        total++;
        if (obs_multi != 0) begin bad++; $display("FAIL fair_cs_onehot got=%0d want=0", obs_multi); end
        exp_last = N - 1;
    endtask

    task automatic test_single();
        bit ok;
        int r, badcs;
        clear_obs(); rdy_rand = 0; rx_dly_max = 0; stall_pct = 0;
        txq[1].push_back({1'b1, 8'h55});
        run_idle(100, ok);
        total++;
        if (!ok || obs_rsp.size() != 1) begin
            bad++; $display("FAIL single_nrsp got=%0d want=1", obs_rsp.size());
        end else begin
            r = obs_rsp_cyc[0];
            total++;
            if (obs_rsp[0] !== {2'd1, 1'b1, 8'hAA}) begin bad++; $display("FAIL single_rsp got=%h want=%h", obs_rsp[0], {2'd1, 1'b1, 8'hAA}); end
            total++;
            if (hist_cs[0] !== 4'hF || hist_cs[1] !== 4'b1101) begin
                bad++; $display("FAIL single_cs_lat got=%b,%b want=1111,1101", hist_cs[0], hist_cs[1]);
            end
            total++;
            if (hs_first != 3) begin bad++; $display("FAIL single_setup got=%0d want=3", hs_first); end
            badcs = 0;
            for (int k = 1; k < r; k++) if (hist_cs[k] !== 4'b1101) badcs++;
            total++;
            if (badcs != 0 || r != 5) begin bad++; $display("FAIL single_cs_hold badcyc=%0d rspcyc=%0d want=0,5", badcs, r); end
            total++;
            if (hist_cs.size() < r + 3 || hist_cs[r] !== 4'hF || hist_cs[r+1] !== 4'hF
                || hist_busy[r+1] !== 1'b1 || hist_busy[r+2] !== 1'b0) begin
                bad++; $display("FAIL single_gap got_len=%0d want cs high, busy 1,1,0", hist_cs.size());
            end
        end
        exp_last = 1;
    endtask

    // Check an N-byte burst from one requester echoed back as complements.
    task automatic test_burst_like(input string nm, input int id, input logic [7:0] b0,
                                   input int nb, input int maxc);
        bit ok;
        int f, badcs;
        logic [10:0] e;
        logic [N-1:0] want_cs;
        clear_obs();
        for (int k = 0; k < nb; k++) txq[id].push_back({1'(k == nb - 1), 8'(b0 + k)});
        run_idle(maxc, ok);
        total++;
        if (!ok || obs_rsp.size() != nb) begin
            bad++; $display("FAIL %s_nrsp got=%0d want=%0d", nm, obs_rsp.size(), nb);
        end else begin
            for (int k = 0; k < nb; k++) begin
                e = {2'(id), 1'(k == nb - 1), ~8'(b0 + k)};
                total++;
                if (obs_rsp[k] !== e) begin bad++; $display("FAIL %s_rsp%0d got=%h want=%h", nm, k, obs_rsp[k], e); end
            end
            want_cs = ~(4'b0001 << id);
            f = -1;
            for (int k = 0; k < hist_cs.size(); k++) if (f < 0 && hist_cs[k] != 4'hF) f = k;
            badcs = 0;
            for (int k = (f < 0 ? 0 : f); k < obs_rsp_cyc[nb-1]; k++) if (hist_cs[k] !== want_cs) badcs++;
            total++;
            if (f < 0 || badcs != 0) begin bad++; $display("FAIL %s_cs_hold first=%0d badcyc=%0d want=0", nm, f, badcs); end
        end
        total++;
        if (obs_err != 0) begin bad++; $display("FAIL %s_error got=%0d want=0", nm, obs_err); end
        exp_last = id;
    endtask

    task automatic test_burst();
        rdy_rand = 1; rx_dly_max = 2; stall_pct = 0;
        test_burst_like("burst", 2, 8'h10, 3, 200);
    endtask

    task automatic test_stall();
        rdy_rand = 0; rx_dly_max = 1; stall_pct = 100; stall_len = 51;
        test_burst_like("stall", 3, 8'h30, 3, 400);
        total++;
        if (obs_rsp_cyc.size() < 3 || obs_rsp_cyc[2] < 100) begin
            bad++; $display("FAIL stall_len got_rsp=%0d want_len>=100", obs_rsp_cyc.size());
        end
        stall_pct = 0;
    endtask

    task automatic test_timeout();
        int post;
        clear_obs(); rdy_rand = 0; rx_dly_max = 0; eng_mute = 1;
        txq[0].push_back({1'b1, 8'h5A});
        post = -1;
        for (int k = 0; k < 1300; k++) begin
            cycle();
            if (post >= 0) post++;
            else if (obs_err > 0) post = 0;
            if (post >= 5) break;
        end
        total++;
        if (obs_err != 1) begin bad++; $display("FAIL tmo_pulses got=%0d want=1", obs_err); end
        total++;
        if (err_cyc - hs_first != TMO + 1) begin
            bad++; $display("FAIL tmo_latency got=%0d want=%0d", err_cyc - hs_first, TMO + 1);
        end
        total++;
        if (err_cs !== 4'hF) begin bad++; $display("FAIL tmo_cs got=%b want=1111", err_cs); end
        total++;
        if (obs_rsp.size() != 0) begin bad++; $display("FAIL tmo_rsp got=%0d want=0", obs_rsp.size()); end
        total++;
        if (hist_busy[$] !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%b want=0", hist_busy[$]); end
        eng_mute = 0; eng_pending = 0;
        exp_last = 0;
    endtask

    task automatic test_random();
        bit ok;
        int nb, len, last, j, nerr;
        logic [8:0] mq [N][$];
        logic [8:0] h;
        logic [10:0] exp_rsp [$];
        int exp_gr [$];
        for (int round = 0; round < 3; round++) begin
            clear_obs(); rdy_rand = 1; rx_dly_max = 3; stall_pct = 30; stall_len = $urandom_range(2, 6);
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                nb = (i == round) ? $urandom_range(1, 2) : $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) begin
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) begin
                        h = {1'(k == len - 1), 8'($urandom)};
                        txq[i].push_back(h); mq[i].push_back(h);
                    end
                end
            end
            // Round-robin over requesters that still hold bursts
            exp_rsp.delete(); exp_gr.delete(); last = exp_last;
            forever begin
                j = -1;
                for (int k = 1; k <= N; k++)
                    if (j < 0 && mq[(last + k) % N].size() > 0) j = (last + k) % N;
                if (j < 0) break;
                exp_gr.push_back(j);
                do begin
                    h = mq[j].pop_front();
                    exp_rsp.push_back({2'(j), h[8], ~h[7:0]});
                end while (!h[8]);
                last = j;
            end
            run_idle(5000, ok);
            total++;
            if (!ok || obs_rsp.size() != exp_rsp.size()) begin
                bad++; $display("FAIL rand%0d_nrsp got=%0d want=%0d", round, obs_rsp.size(), exp_rsp.size());
            end else begin
                nerr = 0;
                for (int k = 0; k < exp_rsp.size(); k++) begin
                    total++;
                    if (obs_rsp[k] !== exp_rsp[k]) begin
                        bad++;
                        if (nerr++ < 4) $display("FAIL rand%0d_rsp%0d got=%h want=%h", round, k, obs_rsp[k], exp_rsp[k]);
                    end
                end
            end
            total++;
            if (grants.size() != exp_gr.size()) begin
                bad++; $display("FAIL rand%0d_ngrant got=%0d want=%0d", round, grants.size(), exp_gr.size());
            end else
                for (int k = 0; k < exp_gr.size(); k++) begin
                    total++;
                    if (grants[k] != exp_gr[k]) begin bad++; $display("FAIL rand%0d_grant%0d got=%0d want=%0d", round, k, grants[k], exp_gr[k]); end
                end
            total++;
            if (obs_multi != 0 || obs_err != 0) begin
                bad++; $display("FAIL rand%0d_cs_err multi=%0d err=%0d want=0,0", round, obs_multi, obs_err);
            end
            exp_last = last;
        end
        stall_pct = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_obs(); rdy_rand = 0; rx_dly_max = 0; eng_mute = 1;
        txq[1].push_back({1'b0, 8'h77});
        txq[1].push_back({1'b1, 8'h78});
        for (int k = 0; k < 20 && hs_first < 0; k++) cycle();
        cycle(); cycle();
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.cs_n !== 4'hF || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_async cs_n=%b busy=%b want=1111,0", bus.cs_n, bus.busy);
        end
        for (int i = 0; i < N; i++) begin txq[i].delete(); stall_left[i] = 0; end
        eng_mute = 0; eng_pending = 0;
        cycle(); cycle();
        reset_n = 1'b1;
        clear_obs();
        for (int i = 0; i < N; i++) txq[i].push_back({1'b1, 8'(8'hC0 + i)});
        run_idle(300, ok);
        total++;
        if (!ok || grants.size() != N || grants[0] != 0) begin
            bad++; $display("FAIL rstmid_first got_n=%0d first=%0d want=%0d,0", grants.size(),
                            grants.size() > 0 ? grants[0] : -1, N);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) stall_left[i] = 0;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
        bus.eng_tx_ready = 1'b0; bus.eng_rx_valid = 1'b0; bus.eng_data_rx = '0;
        clear_obs();
        test_reset();
        test_fairness();
        test_single();
        test_burst();
        test_stall();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end
endmodule
